// File: rtl/seqdet_prog_moore.sv
// seqdet_prog_moore: runtime-programmable serial pattern detector with a
// registered (Moore) match pulse and a saturating hit counter.
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   en           din qualifier
//   din          serial input bit
//   cfg_load     one-cycle strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  pattern, bit [cfg_len-1] expected first, bit [0] last
//   cfg_len      pattern length (0 = never match, >MAX_LEN clamped)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cnt_clear    synchronous clear of hit_count
//   dout         one-cycle match pulse
//   hit_count    saturating match count
module seqdet_prog_moore #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clear,
  output logic               dout,
  output logic [CNT_W-1:0]   hit_count
);

  localparam logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(4'b1011);
  localparam logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4);
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] r_hist, w_hist_nxt;
  logic [LEN_W-1:0]   r_fill, w_fill_nxt;
  logic [MAX_LEN-1:0] r_pat,  w_pat_nxt;
  logic [LEN_W-1:0]   r_len,  w_len_nxt;
  logic               r_ovl,  w_ovl_nxt;
  logic               r_dout, w_dout_nxt;
  logic [CNT_W-1:0]   r_cnt,  w_cnt_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_accept;
  logic               w_match;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEF_PAT;
      r_len  <= DEF_LEN;
      r_ovl  <= 1'b0;
      r_dout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_pat  <= w_pat_nxt;
      r_len  <= w_len_nxt;
      r_ovl  <= w_ovl_nxt;
      r_dout <= w_dout_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Next-state: shift, fill tracking, match compare on the post-shift window
  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_pat_nxt  = r_pat;
    w_len_nxt  = r_len;
    w_ovl_nxt  = r_ovl;
    w_dout_nxt = 1'b0;
    w_cnt_nxt  = r_cnt;
    w_mask     = '0;
    w_match    = 1'b0;
    w_accept   = en && !cfg_load;

    // Low r_len bits of the window take part in the compare
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end

    if (w_accept) begin
      w_hist_nxt = {r_hist[MAX_LEN-2:0], din};
      if (r_fill < LEN_MAX) begin
        w_fill_nxt = r_fill + LEN_W'(1);
      end
    end

    w_match = w_accept && (r_len != '0) && (w_fill_nxt >= r_len) &&
              (((w_hist_nxt ^ r_pat) & w_mask) == '0);

    if (w_match) begin
      w_dout_nxt = 1'b1;
      // Non-overlap: the next match must be built from fresh bits only
      if (!r_ovl) begin
        w_fill_nxt = '0;
      end
    end

    // A clear coinciding with a hit keeps that hit
    if (cnt_clear) begin
      w_cnt_nxt = w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    if (cfg_load) begin
      w_pat_nxt  = cfg_pattern;
      w_len_nxt  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      w_ovl_nxt  = cfg_overlap;
      w_fill_nxt = '0;
    end
  end

  assign dout      = r_dout;
  assign hit_count = r_cnt;

endmodule

// File: tb/tb_seqdet_prog_moore.sv
// Directed self-checking bench for seqdet_prog_moore. A second instance with
// CNT_W=2 shares all inputs and is used for counter saturation.
module tb_seqdet_prog_moore;

  logic       clk;
  logic       reset;
  logic       en;
  logic       din;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clear;
  logic       dout;
  logic [7:0] hit_count;
  logic       dout2;
  logic [1:0] hit2;

  int checks;
  int errors;

  seqdet_prog_moore #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clear(cnt_clear), .dout(dout), .hit_count(hit_count)
  );

  seqdet_prog_moore #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clear(cnt_clear), .dout(dout2), .hit_count(hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; outputs are sampled 1 time unit after the edge
  task automatic drive(input logic e, input logic d, input logic clr);
    @(negedge clk);
    en        = e;
    din       = d;
    cnt_clear = clr;
    cfg_load  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Config load with en=1 and din=1 to show both are ignored
  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    @(negedge clk);
    cfg_load    = 1'b1;
    en          = 1'b1;
    din         = 1'b1;
    cnt_clear   = 1'b0;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    @(posedge clk);
    #1;
    @(negedge clk);
    cfg_load = 1'b0;
    en       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b0; din = 1'b0; cfg_load = 1'b0; cnt_clear = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dout !== 1'b0) begin
      errors++; $display("FAIL reset_dout: got %b expected 0", dout);
    end
    checks++;
    if (hit_count !== 8'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", hit_count);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_default_stream();
    logic [13:0] s;
    logic [13:0] m;
    s = 14'b10110010011011;
    m = 14'b00010000000001;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, s[13-i], 1'b0);
      checks++;
      if (dout !== m[13-i]) begin
        errors++; $display("FAIL default_dout bit %0d: got %b expected %b", i + 1, dout, m[13-i]);
      end
    end
    checks++;
    if (hit_count !== 8'd2) begin
      errors++; $display("FAIL default_count: got %0d expected 2", hit_count);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    logic [6:0] m_no;
    logic [6:0] m_ov;
    s    = 7'b1011011;
    m_no = 7'b0001000;
    m_ov = 7'b0001001;
    load_cfg(8'b0000_1011, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s[6-i], 1'b0);
      checks++;
      if (dout !== m_no[6-i]) begin
        errors++; $display("FAIL nonovl_dout bit %0d: got %b expected %b", i + 1, dout, m_no[6-i]);
      end
    end
    checks++;
    if (hit_count !== 8'd3) begin
      errors++; $display("FAIL nonovl_count: got %0d expected 3", hit_count);
    end
    load_cfg(8'b0000_1011, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s[6-i], 1'b0);
      checks++;
      if (dout !== m_ov[6-i]) begin
        errors++; $display("FAIL ovl_dout bit %0d: got %b expected %b", i + 1, dout, m_ov[6-i]);
      end
    end
    checks++;
    if (hit_count !== 8'd5) begin
      errors++; $display("FAIL ovl_count: got %0d expected 5", hit_count);
    end
  endtask

  task automatic test_len8_and_clamp();
    logic [15:0] s;
    logic [15:0] m;
    logic [3:0]  lens [2];
    int          exp_cnt;
    s = 16'b1110010111100101;
    m = 16'b0000000100000001;
    lens[0] = 4'd8;
    lens[1] = 4'd12;
    exp_cnt = 5;
    for (int k = 0; k < 2; k++) begin
      load_cfg(8'b11100101, lens[k], 1'b0);
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, s[15-i], 1'b0);
        checks++;
        if (dout !== m[15-i]) begin
          errors++; $display("FAIL len%0d_dout bit %0d: got %b expected %b", lens[k], i + 1, dout, m[15-i]);
        end
      end
      exp_cnt += 2;
      checks++;
      if (hit_count !== 8'(exp_cnt)) begin
        errors++; $display("FAIL len%0d_count: got %0d expected %0d", lens[k], hit_count, exp_cnt);
      end
    end
  endtask

  task automatic test_enable();
    logic [5:0] e;
    logic [5:0] d;
    logic [5:0] m;
    e = 6'b101011;
    d = 6'b110111;
    m = 6'b000001;
    load_cfg(8'b0000_1011, 4'd4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(e[5-i], d[5-i], 1'b0);
      checks++;
      if (dout !== m[5-i]) begin
        errors++; $display("FAIL en_dout cycle %0d: got %b expected %b", i + 1, dout, m[5-i]);
      end
    end
    checks++;
    if (hit_count !== 8'd10) begin
      errors++; $display("FAIL en_count: got %0d expected 10", hit_count);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2 [5];
    exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (hit2 !== 2'd0 || hit_count !== 8'd0) begin
      errors++; $display("FAIL clear_alone: got %0d/%0d expected 0/0", hit_count, hit2);
    end
    load_cfg(8'b0000_0001, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (dout !== 1'b1 || hit2 !== exp2[i]) begin
        errors++; $display("FAIL sat hit %0d: got dout=%b cnt=%0d expected dout=1 cnt=%0d", i + 1, dout, hit2, exp2[i]);
      end
    end
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (hit2 !== 2'd1 || hit_count !== 8'd1) begin
      errors++; $display("FAIL clear_with_hit: got %0d/%0d expected 1/1", hit_count, hit2);
    end
    load_cfg(8'hFF, 4'd0, 1'b1);
    checks++;
    if (dout !== 1'b0) begin
      errors++; $display("FAIL load_dout: got %b expected 0", dout);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (dout !== 1'b0) begin
        errors++; $display("FAIL len0_dout bit %0d: got %b expected 0", i + 1, dout);
      end
    end
    // Constant all-ones pattern at full length hits on every bit once filled
    load_cfg(8'hFF, 4'd8, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (dout !== (i >= 7)) begin
        errors++; $display("FAIL full_ovl_dout bit %0d: got %b expected %b", i + 1, dout, (i >= 7));
      end
    end
    checks++;
    if (hit_count !== 8'd4 || hit2 !== 2'd3) begin
      errors++; $display("FAIL full_ovl_count: got %0d/%0d expected 4/3", hit_count, hit2);
    end
  endtask

  task automatic test_reset_midseq();
    logic [2:0] s;
    logic [3:0] p;
    logic [3:0] m;
    s = 3'b101;
    p = 4'b1011;
    m = 4'b0001;
    load_cfg(8'b0000_0001, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s[2-i], 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (dout !== 1'b0 || hit_count !== 8'd0) begin
      errors++; $display("FAIL async_reset: got dout=%b cnt=%0d expected 0/0", dout, hit_count);
    end
    en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, p[3-i], 1'b0);
      checks++;
      if (dout !== m[3-i]) begin
        errors++; $display("FAIL post_reset_dout bit %0d: got %b expected %b", i + 1, dout, m[3-i]);
      end
    end
    checks++;
    if (hit_count !== 8'd1) begin
      errors++; $display("FAIL post_reset_count: got %0d expected 1", hit_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_default_stream();
    test_overlap();
    test_len8_and_clamp();
    test_enable();
    test_saturation();
    test_reset_midseq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
